// File: rtl/systolic_feeder_if.sv
// Upstream beat channel for systolic_feeder: valid/ready handshake carrying one A column-vector,
// one B row-vector, the tile-last marker and the tile mode.
interface systolic_feeder_if #(
    parameter int unsigned ARR_SIZE      = 4,
    parameter int unsigned HORIZONTAL_BW = 16
);
    logic                              s_valid;
    logic                              s_ready;
    logic [HORIZONTAL_BW*ARR_SIZE-1:0] s_row_data;
    logic [HORIZONTAL_BW*ARR_SIZE-1:0] s_col_data;
    logic                              s_last;
    logic                              s_mode;

    modport master (
        output s_valid,
        output s_row_data,
        output s_col_data,
        output s_last,
        output s_mode,
        input  s_ready
    );

    modport slave (
        input  s_valid,
        input  s_row_data,
        input  s_col_data,
        input  s_last,
        input  s_mode,
        output s_ready
    );
endinterface

// File: rtl/systolic_feeder.sv
// Skews operand beats into a systolic array (lane k delayed k+1 cycles) and sequences tiles.
// Optional cycle counter output o_cycle_cnt is enabled by SYSTOLIC_FEEDER_PERF_CNT_EN.
module systolic_feeder #(
    parameter int unsigned ARR_SIZE      = 4,
    parameter int unsigned HORIZONTAL_BW = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    systolic_feeder_if.slave                  s,
    output logic [HORIZONTAL_BW*ARR_SIZE-1:0] horizontal_input,
    output logic [HORIZONTAL_BW*ARR_SIZE-1:0] vertical_input,
    output logic                              i_mode,
    output logic                              o_busy,
    output logic                              o_done,
    output logic [15:0]                       o_beat_cnt
`ifdef SYSTOLIC_FEEDER_PERF_CNT_EN
    ,
    output logic [31:0]                       o_cycle_cnt
`endif
);

    localparam int unsigned Width       = HORIZONTAL_BW * ARR_SIZE;
    localparam int unsigned FlushCycles = 2 * ARR_SIZE;
    localparam int unsigned FlushW      = ($clog2(FlushCycles) > 4) ? $clog2(FlushCycles) : 4;

    typedef enum logic [1:0] {
        StIdle,
        StStream,
        StFlush,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [FlushW-1:0] flush_cnt_q, flush_cnt_d;
    logic              mode_q, mode_d;
    logic [15:0]       beat_cnt_q, beat_cnt_d;

    logic              ready;
    logic              accept;
    logic              first_beat;
    logic [Width-1:0]  row_in;
    logic [Width-1:0]  col_in;

    assign ready      = (state_q == StIdle) || (state_q == StStream);
    assign s.s_ready  = ready;
    assign accept     = s.s_valid && ready;
    assign first_beat = (state_q == StIdle);

    // Cycles without an accepted beat push zeros so the array sees clean bubbles.
    assign row_in = accept ? s.s_row_data : '0;
    assign col_in = accept ? s.s_col_data : '0;

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        unique case (state_q)
            StIdle, StStream: begin
                if (accept && s.s_last) begin
                    state_d     = StFlush;
                    flush_cnt_d = FlushW'(FlushCycles - 1);
                end else if (accept) begin
                    state_d = StStream;
                end
            end
            StFlush: begin
                if (flush_cnt_q == '0) begin
                    state_d = StDone;
                end else begin
                    flush_cnt_d = flush_cnt_q - FlushW'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        mode_d     = mode_q;
        beat_cnt_d = beat_cnt_q;
        if (accept) begin
            if (first_beat) begin
                mode_d     = s.s_mode;
                beat_cnt_d = 16'd1;
            end else if (beat_cnt_q != 16'hFFFF) begin
                beat_cnt_d = beat_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            flush_cnt_q <= '0;
            mode_q      <= 1'b0;
            beat_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            mode_q      <= mode_d;
            beat_cnt_q  <= beat_cnt_d;
        end
    end

    assign i_mode     = mode_q;
    assign o_busy     = (state_q == StStream) || (state_q == StFlush);
    assign o_done     = (state_q == StDone);
    assign o_beat_cnt = beat_cnt_q;

    // Lane k owns a k+1 deep delay line; its last stage drives the array edge directly.
    for (genvar k = 0; k < ARR_SIZE; k++) begin : g_lane
        logic [HORIZONTAL_BW-1:0] row_q [k+1];
        logic [HORIZONTAL_BW-1:0] col_q [k+1];

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                for (int j = 0; j <= k; j++) begin
                    row_q[j] <= '0;
                    col_q[j] <= '0;
                end
            end else begin
                row_q[0] <= row_in[k*HORIZONTAL_BW +: HORIZONTAL_BW];
                col_q[0] <= col_in[k*HORIZONTAL_BW +: HORIZONTAL_BW];
                for (int j = 1; j <= k; j++) begin
                    row_q[j] <= row_q[j-1];
                    col_q[j] <= col_q[j-1];
                end
            end
        end

        assign horizontal_input[k*HORIZONTAL_BW +: HORIZONTAL_BW] = row_q[k];
        assign vertical_input[k*HORIZONTAL_BW +: HORIZONTAL_BW]   = col_q[k];
    end

`ifdef SYSTOLIC_FEEDER_PERF_CNT_EN
    logic [31:0] cycle_cnt_q, cycle_cnt_d;

    always_comb begin
        cycle_cnt_d = cycle_cnt_q;
        if (accept && first_beat) begin
            cycle_cnt_d = 32'd1;
        end else if (state_q != StIdle) begin
            cycle_cnt_d = cycle_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycle_cnt_q <= '0;
        end else begin
            cycle_cnt_q <= cycle_cnt_d;
        end
    end

    // While a tile is in flight the current cycle is part of the span, so DONE reads the total.
    assign o_cycle_cnt = (state_q != StIdle) ? cycle_cnt_q + 32'd1 : cycle_cnt_q;
`endif

endmodule
